// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS frequency sweep controller.
package dds_ctrl_pkg;

  localparam int DEFAULT_WORD_W  = 32;
  localparam int DEFAULT_DWELL_W = 24;
  localparam int POINT_IDX_W     = 16;

  // IDLE: parked, DAC disabled. DWELL: holding a sweep point.
  // STEP: single cycle where the next tuning word is computed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2
  } state_t;

endpackage

// File: rtl/dds_sweep_controller_dwell_timer.sv
// Loadable down-counter that measures how long each sweep point is held.
// A load value of zero is treated as one so every point lasts at least a cycle.
module dwell_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= (value == '0) ? W'(1) : value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // The count reads one during the last cycle of the hold period.
  assign expire = (count == W'(1));

endmodule

// File: rtl/dds_sweep_controller.sv
// Stepped frequency sweep sequencer: drives the tuning word of the sine
// generator feeding the DAC904 and gates the DAC output enable.
module dds_sweep_controller
  import dds_ctrl_pkg::*;
#(
  parameter int WORD_W  = DEFAULT_WORD_W,
  parameter int DWELL_W = DEFAULT_DWELL_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop,
  input  logic [WORD_W-1:0]      start_word,
  input  logic [WORD_W-1:0]      stop_word,
  input  logic [WORD_W-1:0]      step_word,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [WORD_W-1:0]      freq_word,
  output logic                   out_en,
  output logic                   busy,
  output logic                   done,
  output logic [POINT_IDX_W-1:0] point_idx
);

  state_t state, state_next;

  logic [WORD_W-1:0]      start_q, stop_q, step_q, freq_q;
  logic [DWELL_W-1:0]     dwell_q;
  logic                   down_q;
  logic [POINT_IDX_W-1:0] idx_q;
  logic                   done_q;

  logic                   timer_load, timer_expire;
  logic [DWELL_W-1:0]     timer_value;
  logic                   latch_cfg, advance, restart, go_idle, set_done;
  logic                   sweep_end;
  logic [WORD_W:0]        sum_ext, diff_ext;
  logic [WORD_W-1:0]      next_word;

  // At the start edge the config registers are not loaded yet, so the
  // timer takes its dwell straight from the input port.
  assign timer_value = (state == IDLE) ? dwell : dwell_q;

  dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .value  (timer_value),
    .expire (timer_expire)
  );

  // A sweep finishes once it sits on the stop word, or immediately if the
  // step is zero (it would otherwise never reach the stop word).
  assign sweep_end = (freq_q == stop_q) || (step_q == '0);

  // Next tuning word, computed one bit wider so a wrap past either end of
  // the word range is caught as an overshoot and clamped to the stop word.
  always_comb begin
    sum_ext   = {1'b0, freq_q} + {1'b0, step_q};
    diff_ext  = {1'b0, freq_q} - {1'b0, step_q};
    next_word = stop_q;
    if (down_q) begin
      if (!diff_ext[WORD_W] && (diff_ext[WORD_W-1:0] > stop_q))
        next_word = diff_ext[WORD_W-1:0];
    end else begin
      if (!sum_ext[WORD_W] && (sum_ext[WORD_W-1:0] < stop_q))
        next_word = sum_ext[WORD_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control; abort overrides everything else.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    latch_cfg  = 1'b0;
    advance    = 1'b0;
    restart    = 1'b0;
    go_idle    = 1'b0;
    set_done   = 1'b0;
    if (abort) begin
      state_next = IDLE;
      go_idle    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            latch_cfg  = 1'b1;
            timer_load = 1'b1;
            state_next = DWELL;
          end
        end
        DWELL: begin
          if (timer_expire) begin
            if (!sweep_end) begin
              state_next = STEP;
            end else if (loop) begin
              restart    = 1'b1;
              timer_load = 1'b1;
            end else begin
              go_idle    = 1'b1;
              set_done   = 1'b1;
              state_next = IDLE;
            end
          end
        end
        STEP: begin
          advance    = 1'b1;
          timer_load = 1'b1;
          state_next = DWELL;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Config latch, tuning word, point index and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      down_q  <= 1'b0;
      freq_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= set_done;
      if (latch_cfg) begin
        start_q <= start_word;
        stop_q  <= stop_word;
        step_q  <= step_word;
        dwell_q <= dwell;
        down_q  <= (stop_word < start_word);
        freq_q  <= start_word;
        idx_q   <= '0;
      end else if (go_idle) begin
        freq_q <= '0;
      end else if (restart) begin
        freq_q <= start_q;
        idx_q  <= '0;
      end else if (advance) begin
        freq_q <= next_word;
        idx_q  <= idx_q + POINT_IDX_W'(1);
      end
    end
  end

  assign busy      = (state != IDLE);
  assign out_en    = busy;
  assign done      = done_q;
  assign freq_word = freq_q;
  assign point_idx = idx_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Scoreboard bench for dds_sweep_controller: a behavioural sweep model fills
// a queue of expected per-cycle outputs that are popped as the DUT runs.
module tb_dds_sweep_controller;

  typedef struct packed {
    logic        busy;
    logic        out_en;
    logic        done;
    logic [15:0] idx;
    logic [31:0] freq;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        start, abort, loop;
  logic [31:0] start_word, stop_word, step_word;
  logic [23:0] dwell;
  logic [31:0] freq_word;
  logic        out_en, busy, done;
  logic [15:0] point_idx;

  obs_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  dds_sweep_controller #(.WORD_W(32), .DWELL_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .loop       (loop),
    .start_word (start_word),
    .stop_word  (stop_word),
    .step_word  (step_word),
    .dwell      (dwell),
    .freq_word  (freq_word),
    .out_en     (out_en),
    .busy       (busy),
    .done       (done),
    .point_idx  (point_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic b, input logic oe, input logic d,
                              input logic [15:0] i, input logic [31:0] f);
    mk = {b, oe, d, i, f};
  endfunction

  // Expected trace of one sweep: each point held max(dwell,1) cycles, a STEP
  // cycle between points, clamping to the stop word on any overshoot.
  task automatic push_sweep(input logic [31:0] s, input logic [31:0] e,
                            input logic [31:0] st, input int dw, input bit finish);
    longint pt, nx, le, ls;
    int     hold;
    int     idx;
    bit     down;
    pt   = longint'(s);
    le   = longint'(e);
    ls   = longint'(st);
    hold = (dw == 0) ? 1 : dw;
    idx  = 0;
    down = (le < pt);
    while (1) begin
      repeat (hold) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 16'(idx), pt[31:0]));
      if (pt == le || ls == 0) break;
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 16'(idx), pt[31:0]));
      if (down) begin
        nx = pt - ls;
        if (nx < le) nx = le;
      end else begin
        nx = pt + ls;
        if (nx > le) nx = le;
      end
      pt  = nx;
      idx = idx + 1;
    end
    if (finish) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 16'(idx), 32'h0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 16'(idx), 32'h0));
    end
  endtask

  // Pulse start with the given config, then pop and compare one expected
  // entry per cycle. Optionally assert abort or a stray start after a
  // given number of compared cycles.
  task automatic run_sweep(input string name, input logic [31:0] s,
                           input logic [31:0] e, input logic [31:0] st,
                           input logic [23:0] dw, input logic lp,
                           input int abort_at, input int restart_at);
    obs_t got, exp;
    int   n;
    n = 0;
    @(negedge clk);
    start_word = s;
    stop_word  = e;
    step_word  = st;
    dwell      = dw;
    loop       = lp;
    start      = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      n     = n + 1;
      got   = {busy, out_en, done, point_idx, freq_word};
      exp   = exp_q.pop_front();
      vectors = vectors + 1;
      if (got !== exp) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL %s cycle %0d: got busy/oe/done/idx/freq=%h expected %h",
                 name, n, got, exp);
      end
      if (n == abort_at) abort = 1'b1;
      if (n == restart_at) begin
        start      = 1'b1;
        start_word = 32'h0BAD_0000;
        stop_word  = 32'h0000_0001;
        step_word  = 32'h0000_0777;
        dwell      = 24'd1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    loop  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors = vectors + 5;
    if (freq_word !== 32'h0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL reset_freq: got %h expected 0", freq_word);
    end
    if (out_en !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL reset_out_en: got %b expected 0", out_en);
    end
    if (busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    if (done !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    if (point_idx !== 16'h0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL reset_idx: got %h expected 0", point_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_up_sweep();
    push_sweep(32'd1000, 32'd3000, 32'd1000, 4, 1'b1);
    run_sweep("up_sweep", 32'd1000, 32'd3000, 32'd1000, 24'd4, 1'b0, -1, -1);
  endtask

  task automatic test_clamp_down();
    push_sweep(32'd1000, 32'd2500, 32'd1000, 2, 1'b1);
    run_sweep("clamp_up", 32'd1000, 32'd2500, 32'd1000, 24'd2, 1'b0, -1, -1);
    push_sweep(32'd3000, 32'd500, 32'd1000, 2, 1'b1);
    run_sweep("down_sweep", 32'd3000, 32'd500, 32'd1000, 24'd2, 1'b0, -1, -1);
  endtask

  task automatic test_wrap_guard();
    push_sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 2, 1'b1);
    run_sweep("wrap_up", 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 24'd2, 1'b0, -1, -1);
    push_sweep(32'h0000_0100, 32'h0000_0000, 32'h300, 1, 1'b1);
    run_sweep("wrap_down", 32'h0000_0100, 32'h0000_0000, 32'h300, 24'd1, 1'b0, -1, -1);
  endtask

  task automatic test_degenerate();
    push_sweep(32'd1234, 32'd9999, 32'd0, 0, 1'b1);
    run_sweep("step0_dwell0", 32'd1234, 32'd9999, 32'd0, 24'd0, 1'b0, -1, -1);
    push_sweep(32'd777, 32'd777, 32'd50, 3, 1'b1);
    run_sweep("start_eq_stop", 32'd777, 32'd777, 32'd50, 24'd3, 1'b0, -1, -1);
  endtask

  task automatic test_loop_abort();
    // First pass with loop held: no done, then back to the start word.
    push_sweep(32'd100, 32'd300, 32'd100, 2, 1'b0);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 16'd0, 32'd100));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 16'd0, 32'd100));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 16'd0, 32'd100));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 16'd1, 32'd200));
    // Abort sampled during point 2 of the second pass.
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 16'd1, 32'd0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 16'd1, 32'd0));
    run_sweep("loop_abort", 32'd100, 32'd300, 32'd100, 24'd2, 1'b1, 12, -1);
  endtask

  task automatic test_back_to_back();
    // A stray start mid-sweep with different config must be ignored.
    push_sweep(32'd5000, 32'd8000, 32'd1500, 3, 1'b1);
    run_sweep("start_while_busy", 32'd5000, 32'd8000, 32'd1500, 24'd3, 1'b0, -1, 4);
    push_sweep(32'd40, 32'd10, 32'd10, 1, 1'b1);
    run_sweep("back_to_back", 32'd40, 32'd10, 32'd10, 24'd1, 1'b0, -1, -1);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start_word = 32'd1000;
    stop_word  = 32'd5000;
    step_word  = 32'd1000;
    dwell      = 24'd10;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors = vectors + 1;
    if (busy !== 1'b1 || freq_word !== 32'd1000) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL pre_reset_dwell: got busy=%b freq=%0d expected busy=1 freq=1000",
               busy, freq_word);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors = vectors + 1;
    if ({busy, out_en, done, point_idx, freq_word} !== 51'h0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL async_reset: got busy/oe/done/idx/freq=%h expected 0",
               {busy, out_en, done, point_idx, freq_word});
    end
    @(negedge clk);
    vectors = vectors + 1;
    if (done !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL reset_no_done: got %b expected 0", done);
    end
    #2 rst_n = 1'b1;
    push_sweep(32'd500, 32'd700, 32'd100, 1, 1'b1);
    run_sweep("after_reset", 32'd500, 32'd700, 32'd100, 24'd1, 1'b0, -1, -1);
  endtask

  initial begin
    start      = 1'b0;
    abort      = 1'b0;
    loop       = 1'b0;
    start_word = '0;
    stop_word  = '0;
    step_word  = '0;
    dwell      = '0;
    rst_n      = 1'b0;
    $display("[TB] dds_sweep_controller bench starting");
    test_reset();
    test_up_sweep();
    test_clamp_down();
    test_wrap_guard();
    test_degenerate();
    test_loop_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
